spi_master_arb: RTL and testbench
=================================

SPI_MASTER_ARB -- requirements
Module: spi_master_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters, each with its own slave select (range 2..8).
REQ-002 SHALL have parameter CLK_DIV, default 4, clk_i cycles per SCK half-period (minimum 2).
REQ-003 SHALL have port clk_i  input  1  system clock; the only clock, all logic on its rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_i  input  NUM_REQ  per-requester transfer request, level.
REQ-006 SHALL have port tx_data_i  input  8*NUM_REQ  per-requester transmit byte; slice i = bits [8i+7:8i].
REQ-007 SHALL have port done_o  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-008 SHALL have port rx_data_o  output  8  last received byte, valid from the cycle done_o pulses.
REQ-009 SHALL have port busy_o  output  1  high from grant until the end of the DONE state.
REQ-010 SHALL have ports SCK, MOSI (output 1 each), MISO (input 1) and SS_n (output NUM_REQ, active-low selects).

Function
REQ-011 States SHALL be IDLE, SETUP, SHIFT, HOLD, DONE; any unused encoding SHALL return to IDLE.
REQ-012 IDLE with any req_i bit high: grant index g chosen, tx_data_i slice g latched, SETUP entered; SS_n[g] low from the next cycle.
REQ-013 SPI mode 0, MSB first: SCK idle low; MOSI = latched bit 7 throughout SETUP; SETUP lasts CLK_DIV cycles, SCK low.
REQ-014 SHIFT: 8 bits, each SCK high for CLK_DIV cycles, then low for CLK_DIV cycles.
REQ-015 MISO SHALL be sampled into the rx shift register in the last clk_i cycle of each SCK-high phase.
REQ-016 MOSI SHALL advance to the next bit on each SCK falling edge; after the 8th falling edge HOLD is entered.
REQ-017 HOLD: CLK_DIV cycles, SCK low, SS_n[g] still low; total SS_n low time = 18*CLK_DIV cycles.
REQ-018 DONE: exactly one cycle; all SS_n high, done_o[g]=1, rx_data_o loaded; IDLE follows, so SS_n stays high at least 2 cycles between transfers.
REQ-019 Requester handshake: hold req_i and tx_data_i stable until done_o; a req_i drop after grant SHALL NOT abort the transfer.
REQ-020 Requests changing during a transfer SHALL be ignored until IDLE.
REQ-021 At most one SS_n bit SHALL ever be low; SS_n SHALL be all-ones outside SETUP/SHIFT/HOLD.
REQ-022 Bit and half-period counters SHALL be sized to CLK_DIV and 8 exactly, with no wrap into a 9th bit.

Reset
REQ-023 reset_i SHALL force state IDLE, SCK=0, MOSI=0, SS_n all ones, done_o=0, busy_o=0, rx_data_o=8'h00, and round-robin pointer=0.
REQ-024 reset_i asserted mid-transfer SHALL abandon the transfer in the next cycle with no done_o pulse.

Configuration
REQ-025 With macro SPI_ARB_ROUND_ROBIN_EN defined: grant search starts at (last grant + 1) mod NUM_REQ.
REQ-026 Without SPI_ARB_ROUND_ROBIN_EN: fixed priority, lowest active index wins, and the pointer register is absent.

Structure
REQ-027 Package spi_arb_pkg SHALL hold the state enum typedef and the data width constant (8).
REQ-028 Grant selection SHALL be a sub-module spi_arb_grant (request vector in, one-hot grant plus index out, combinational plus pointer).

Verification
REQ-029 CLK_DIV=4, req_i=2'b01, tx_data_i[7:0]=8'hA5, MISO loopback from MOSI -> SS_n[0] low for 72 cycles; MOSI sequence 1,0,1,0,0,1,0,1; done_o[0] pulse; rx_data_o=8'hA5.
REQ-030 MISO tied 1, tx 8'h00 -> MOSI held 0; rx_data_o=8'hFF; exactly 8 SCK rising edges.
REQ-031 req_i=2'b11 held, SPI_ARB_ROUND_ROBIN_EN defined -> grants 0,1,0,1; undefined -> grants 0,0,0.
REQ-032 reset_i pulsed during the 4th bit -> next cycle SS_n=2'b11, SCK=0, no done_o; a new request then completes normally.
REQ-033 req_i[0] dropped after the 2nd SCK edge -> transfer still completes with a done_o[0] pulse.
REQ-034 Back-to-back requests -> SS_n all ones for at least 2 cycles between transfers; SS_n never has two bits low at once (assertion).

Source files
------------

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state encoding and data width for the arbitrated SPI master
package spi_arb_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_e;
endpackage

// File: rtl/spi_arb_grant.sv
// spi_arb_grant: picks the first active request searching upward from ptr_i (wrapping)
module spi_arb_grant #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int IW = $clog2(N);
  always_comb begin
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) idx_o = IW'((int'(ptr_i) + k) % N);
    gnt_o = |req_i ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/spi_master_arb.sv
// spi_master_arb: mode-0 SPI master shared by NUM_REQ requesters; SPI_ARB_ROUND_ROBIN_EN selects round-robin grant
module spi_master_arb
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [DATA_W*NUM_REQ-1:0] tx_data_i,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]         rx_data_o,
  output logic                      busy_o,
  output logic                      SCK,
  output logic                      MOSI,
  input  logic                      MISO,
  output logic [NUM_REQ-1:0]        SS_n
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CLK_DIV);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic hi_q, hi_d, last, active;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rxd_q, rxd_d;
  logic [IW-1:0] g_q, g_d, idx, ptr;
  logic [NUM_REQ-1:0] gnt;
`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif
  spi_arb_grant #(.N(NUM_REQ)) u_grant (.req_i(req_i), .ptr_i(ptr), .gnt_o(gnt), .idx_o(idx));
  assign last = cnt_q == CW'(CLK_DIV - 1);
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxd_q   <= '0;
      g_q     <= '0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxd_q   <= rxd_d;
      g_q     <= g_d;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    hi_d = hi_q;
    tx_d = tx_q;
    rx_d = rx_q;
    rxd_d = rxd_q;
    g_d = g_q;
`ifdef SPI_ARB_ROUND_ROBIN_EN
    ptr_d = ptr_q;
`endif
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = SETUP;
        cnt_d = '0;
        g_d = idx;
        tx_d = tx_data_i[idx*DATA_W +: DATA_W];
`ifdef SPI_ARB_ROUND_ROBIN_EN
        ptr_d = idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
`endif
      end
      SETUP: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          state_d = SHIFT;
          hi_d = 1'b1;
          bit_d = '0;
        end
      end
      SHIFT: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        // end of a high phase is the falling edge: sample MISO and advance MOSI together
        if (last) begin
          hi_d = !hi_q;
          if (hi_q) begin
            rx_d = {rx_q[DATA_W-2:0], MISO};
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
          end else if (bit_q == 3'd7) state_d = HOLD;
          else bit_d = bit_q + 1'b1;
        end
      end
      HOLD: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          rxd_d = rx_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    active = state_q == SETUP || state_q == SHIFT || state_q == HOLD;
    SCK = state_q == SHIFT && hi_q;
    MOSI = active ? tx_q[DATA_W-1] : 1'b0;
    SS_n = active ? ~(NUM_REQ'(1) << g_q) : '1;
    done_o = state_q == DONE ? NUM_REQ'(1) << g_q : '0;
    busy_o = state_q != IDLE;
    rx_data_o = rxd_q;
  end
endmodule

// File: tb/tb_spi_master_arb.sv
// tb_spi_master_arb: randomized directed bench with a transaction-level reference model
module tb_spi_master_arb;
  localparam int NR = 2;
  localparam int CD = 4;
  localparam logic [NR-1:0] ALL1 = '1;
  localparam logic [NR-1:0] ZERO = '0;
  logic clk = 0, reset_i = 1;
  logic [NR-1:0] req_i = '0, done_o, SS_n;
  logic [8*NR-1:0] tx_data_i = '0;
  logic [7:0] rx_data_o;
  logic busy_o, SCK, MOSI, MISO;
  logic loopback = 1, miso_fix = 0;
  int checks = 0, fails = 0, ptr = 0, gap = 0;
  assign MISO = loopback ? MOSI : miso_fix;
  always #5 clk = ~clk;
  spi_master_arb #(.NUM_REQ(NR), .CLK_DIV(CD)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .tx_data_i(tx_data_i),
    .done_o(done_o), .rx_data_o(rx_data_o), .busy_o(busy_o),
    .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (!reset_i) begin
      checks++;
      assert ($countones(~SS_n) <= 1) else begin
        fails++;
        $error("FAIL ss_onehot: observed %b expected at most one low", SS_n);
      end
    end
  function automatic int pick(input logic [NR-1:0] r);
`ifdef SPI_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < NR; k++) if (r[(ptr + k) % NR]) return (ptr + k) % NR;
`else
    for (int k = 0; k < NR; k++) if (r[k]) return k;
`endif
    return 0;
  endfunction
  task automatic xfer(input logic [NR-1:0] r, input logic [8*NR-1:0] d, input bit keep,
                      input int drop_edges, input int abort_rise, input bit b2b);
    int g, n, low, rises, edges;
    logic [7:0] tx, mseq, exp_rx;
    logic [NR-1:0] sel, nsel;
    logic prev, bad, dbad;
    g = pick(r);
    ptr = (g + 1) % NR;
    tx = d[g*8 +: 8];
    exp_rx = loopback ? tx : {8{miso_fix}};
    sel = NR'(1) << g;
    nsel = ~sel;
    req_i = r;
    tx_data_i = d;
    n = 0;
    while (SS_n == ALL1 && n < 10) begin
      @(negedge clk);
      n++;
      if (SS_n == ALL1) gap++;
    end
    if (b2b) chk("ss_gap_ge2", gap >= 2, 1);
    chk("grant_select", SS_n, nsel);
    low = 0; rises = 0; edges = 0; prev = 0; bad = 0; mseq = 0;
    while (SS_n != ALL1 && low < 40*CD) begin
      if (SS_n !== nsel || done_o !== ZERO) bad = 1;
      if (SCK && !prev) begin
        rises++;
        edges++;
        mseq = {mseq[6:0], MOSI};
      end else if (!SCK && prev) edges++;
      prev = SCK;
      if (drop_edges > 0 && edges == drop_edges) req_i = '0;
      if (abort_rise > 0 && rises == abort_rise && SCK) begin
        reset_i = 1;
        req_i = '0;
        @(negedge clk);
        reset_i = 0;
        ptr = 0;
        chk("abort_ss_n", SS_n, ALL1);
        chk("abort_sck", SCK, 0);
        chk("abort_done", done_o, ZERO);
        chk("abort_busy", busy_o, 0);
        dbad = 0;
        repeat (2*CD) begin
          @(negedge clk);
          if (done_o !== ZERO || SS_n !== ALL1) dbad = 1;
        end
        chk("abort_quiet", dbad, 0);
        gap = 2;
        return;
      end
      @(negedge clk);
      low++;
    end
    chk("ss_low_cycles", low, 18*CD);
    chk("ss_stable", bad, 0);
    chk("sck_rises", rises, 8);
    chk("mosi_seq", mseq, tx);
    chk("done_pulse", done_o, sel);
    chk("rx_data", rx_data_o, exp_rx);
    chk("busy_in_done", busy_o, 1);
    gap = 1;
    if (!keep) req_i = '0;
    @(negedge clk);
    gap++;
    chk("done_one_cycle", done_o, ZERO);
    chk("busy_after_done", busy_o, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ss_n", SS_n, ALL1);
    chk("rst_sck", SCK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_done", done_o, ZERO);
    chk("rst_busy", busy_o, 0);
    chk("rst_rx", rx_data_o, 0);
    reset_i = 0;
    @(negedge clk);
    loopback = 1;
    xfer(2'b01, 16'h00A5, 0, 0, 0, 0);
    loopback = 0;
    miso_fix = 1;
    xfer(2'b01, 16'h0000, 0, 0, 0, 0);
    reset_i = 1;
    @(negedge clk);
    reset_i = 0;
    ptr = 0;
    loopback = 1;
`ifdef SPI_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) xfer(2'b11, 16'($urandom), i < 3, 0, 0, i > 0);
`else
    for (int i = 0; i < 3; i++) xfer(2'b11, 16'($urandom), i < 2, 0, 0, i > 0);
`endif
    xfer(2'b01, 16'($urandom), 0, 0, 4, 0);
    xfer(2'b10, 16'($urandom), 0, 0, 0, 0);
    xfer(2'b01, 16'($urandom), 0, 2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      loopback = 1'($urandom);
      miso_fix = 1'($urandom);
      xfer(2'($urandom_range(1, 3)), 16'($urandom), 0, 0, 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
